// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } fetch_state_t;

    localparam int unsigned FETCH_RESET_PC = 0;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch <-> decode/ROM signal bundle. Optional FETCH_PERF_CNT_EN adds fetch_count.
interface instr_fetch_unit_if #(
    parameter int data_length = 32,
    parameter int mem_length  = 32
);
    localparam int ADDR_W = $clog2(mem_length);

    logic                   stall;
    logic                   branch_valid;
    logic [ADDR_W-1:0]      branch_target;
    logic                   halt;
    logic [ADDR_W-1:0]      rom_address;
    logic [data_length-1:0] rom_data;
    logic [data_length-1:0] instr;
    logic [ADDR_W-1:0]      instr_pc;
    logic                   instr_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]            fetch_count;

    modport master (
        input  stall, branch_valid, branch_target, halt, rom_data,
        output rom_address, instr, instr_pc, instr_valid, fetch_count
    );

    modport slave (
        output stall, branch_valid, branch_target, halt, rom_data,
        input  rom_address, instr, instr_pc, instr_valid, fetch_count
    );
`else
    modport master (
        input  stall, branch_valid, branch_target, halt, rom_data,
        output rom_address, instr, instr_pc, instr_valid
    );

    modport slave (
        output stall, branch_valid, branch_target, halt, rom_data,
        input  rom_address, instr, instr_pc, instr_valid
    );
`endif

endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the 1-cycle ROM, realigns data with its address.
// Optional FETCH_PERF_CNT_EN adds a saturating delivered-instruction counter.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int data_length = 32,
    parameter int mem_length  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_unit_if.master   bus
);

    localparam int ADDR_W = $clog2(mem_length);

    fetch_state_t           r_state_q, w_state_d;
    logic [ADDR_W-1:0]      r_pc_q, w_pc_d;
    logic [ADDR_W-1:0]      r_inflight_pc_q, w_inflight_pc_d;
    logic                   r_inflight_valid_q, w_inflight_valid_d;
    logic [data_length-1:0] r_instr, w_instr_d;
    logic [ADDR_W-1:0]      r_instr_pc, w_instr_pc_d;
    logic                   r_instr_valid, w_instr_valid_d;
    logic [ADDR_W-1:0]      w_rom_address;

    // Replaying the in-flight address on stall keeps rom_data aligned with it.
    always_comb begin
        w_rom_address = r_pc_q;
        if (!rst_n)                   w_rom_address = '0;
        else if (r_state_q == HALTED) w_rom_address = r_inflight_pc_q;
        else if (bus.branch_valid)    w_rom_address = bus.branch_target;
        else if (bus.stall)           w_rom_address = r_inflight_pc_q;
    end

    always_comb begin
        w_state_d          = r_state_q;
        w_pc_d             = r_pc_q;
        w_inflight_pc_d    = r_inflight_pc_q;
        w_inflight_valid_d = r_inflight_valid_q;
        w_instr_d          = r_instr;
        w_instr_pc_d       = r_instr_pc;
        w_instr_valid_d    = r_instr_valid;

        if (r_state_q != HALTED) begin
            if (bus.halt) begin
                w_state_d          = HALTED;
                w_instr_valid_d    = 1'b0;
                w_inflight_valid_d = 1'b0;
            end else if (bus.branch_valid) begin
                w_state_d          = RUN;
                w_instr_valid_d    = 1'b0;
                w_inflight_pc_d    = bus.branch_target;
                w_inflight_valid_d = 1'b1;
                w_pc_d             = bus.branch_target + ADDR_W'(1);
            end else if (!bus.stall) begin
                if (r_state_q == BOOT) begin
                    w_state_d          = RUN;
                    w_inflight_pc_d    = ADDR_W'(FETCH_RESET_PC);
                    w_inflight_valid_d = 1'b1;
                    w_pc_d             = ADDR_W'(FETCH_RESET_PC + 1);
                end else begin
                    w_instr_d          = bus.rom_data;
                    w_instr_pc_d       = r_inflight_pc_q;
                    w_instr_valid_d    = r_inflight_valid_q;
                    w_inflight_pc_d    = r_pc_q;
                    w_inflight_valid_d = 1'b1;
                    w_pc_d             = r_pc_q + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q          <= BOOT;
            r_pc_q             <= ADDR_W'(FETCH_RESET_PC);
            r_inflight_pc_q    <= '0;
            r_inflight_valid_q <= 1'b0;
            r_instr            <= '0;
            r_instr_pc         <= '0;
            r_instr_valid      <= 1'b0;
        end else begin
            r_state_q          <= w_state_d;
            r_pc_q             <= w_pc_d;
            r_inflight_pc_q    <= w_inflight_pc_d;
            r_inflight_valid_q <= w_inflight_valid_d;
            r_instr            <= w_instr_d;
            r_instr_pc         <= w_instr_pc_d;
            r_instr_valid      <= w_instr_valid_d;
        end
    end

    assign bus.rom_address = w_rom_address;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;

    // Counts instructions actually accepted by decode; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
        end else if (r_instr_valid && !bus.stall && (r_fetch_count != '1)) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign bus.fetch_count = r_fetch_count;
`endif

endmodule
